// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq: duty-cycle sequencer feeding a downstream PWM stage.
//   Holds a DEPTH-entry table of compare values and plays it back, one entry per
//   (cfg_repeat_i+1) PWM periods, either once or in a loop.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i/addr/data  table write port (any state, visible next cycle)
//   cfg_last_i      index of last active entry
//   cfg_repeat_i    periods per entry minus one
//   cfg_loop_i      wrap to entry 0 after the last entry instead of finishing
//   start_i/stop_i  begin playback from IDLE / abort playback
//   period_start_i  period boundary pulse from the PWM
//   cmp_value_o     registered compare value to the PWM
//   pwm_set_o       one-cycle PWM counter restart pulse
//   busy_o          high outside IDLE
//   done_o          one-cycle pulse when a one-shot sequence completes
//   idx_o           index of the entry currently on cmp_value_o
module pwm_duty_seq #(
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned REPEAT_WIDTH = 4,
  parameter logic [COUNTER_WIDTH-1:0] IDLE_CMP = {COUNTER_WIDTH{1'b1}},
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [COUNTER_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]            cfg_last_i,
  input  logic [REPEAT_WIDTH-1:0]  cfg_repeat_i,
  input  logic                     cfg_loop_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     period_start_i,
  output logic [COUNTER_WIDTH-1:0] cmp_value_o,
  output logic                     pwm_set_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AW-1:0]            idx_o
);

  localparam logic [AW-1:0]           IdxZero = '0;
  localparam logic [AW-1:0]           IdxOne  = 1;
  localparam logic [REPEAT_WIDTH-1:0] RepOne  = 1;

  typedef enum logic [1:0] {StIdle, StArm, StSync, StRun} state_e;

  state_e                     state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   cmp_q, cmp_d;
  logic [AW-1:0]              idx_q, idx_d;
  logic [REPEAT_WIDTH-1:0]    rep_q, rep_d;
  logic                       set_q, set_d;
  logic                       done_q, done_d;
  logic [COUNTER_WIDTH-1:0]   tbl_q [DEPTH];
  logic [AW-1:0]              idx_inc;

  assign idx_inc = idx_q + IdxOne;

  // Pattern table is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tbl_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    set_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d = StArm;
          cmp_d   = tbl_q[IdxZero];
          idx_d   = IdxZero;
          rep_d   = '0;
          set_d   = 1'b1;
        end
      end
      // pwm_set_o is high during ARM; any period_start_i here predates the restart.
      StArm: state_d = StSync;
      // First pulse after the restart opens period 1 and is not counted.
      StSync: begin
        if (period_start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (period_start_i) begin
          if (rep_q < cfg_repeat_i) begin
            rep_d = rep_q + RepOne;
          end else begin
            rep_d = '0;
            // idx_inc is only used when idx_q < cfg_last_i, so it never runs off the table.
            if (idx_q < cfg_last_i) begin
              idx_d = idx_inc;
              cmp_d = tbl_q[idx_inc];
            end else if (cfg_loop_i) begin
              idx_d = IdxZero;
              cmp_d = tbl_q[IdxZero];
            end else begin
              cmp_d   = IDLE_CMP;
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides start and any advance on the same edge.
    if (stop_i && (state_q != StIdle)) begin
      state_d = StIdle;
      cmp_d   = IDLE_CMP;
      idx_d   = idx_q;
      rep_d   = '0;
      set_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cmp_q   <= IDLE_CMP;
      idx_q   <= '0;
      rep_q   <= '0;
      set_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      set_q   <= set_d;
      done_q  <= done_d;
    end
  end

  assign cmp_value_o = cmp_q;
  assign pwm_set_o   = set_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign idx_o       = idx_q;

endmodule
